alaw_encoder_stream: RTL and testbench

ALAW_ENCODER_STREAM -- requirements
Module: alaw_encoder_stream

---
 rtl/alaw_encoder_stream.sv | 107 ++++++++++
 tb/tb_alaw_encoder_stream.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alaw_encoder_stream.sv
// A-law encoder with a two-stage valid/ready pipeline.
// Stage 1 captures sign, magnitude and segment; stage 2 selects the
// mantissa and registers the 8-bit code {sign, seg, mant} (no even-bit
// inversion). A saturating counter tracks accepted clipping samples.
module alaw_encoder_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [12:0]      in_lin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_alaw,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_count,
  output logic [CNT_W-1:0] clip_count
);

  logic        en1;
  logic        en2;
  logic        accept;
  logic        in_clip;
  logic [2:0]  in_seg;
  logic [3:0]  s1_mant;

  logic        s1_valid;
  logic        s1_sign;
  logic [11:0] s1_mag;
  logic [2:0]  s1_seg;

  // Handshake: a stage advances when its successor can take its contents.
  // Reset forces in_ready high so the upstream never stalls on a block that
  // is discarding everything anyway.
  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = rst || en1;
  assign accept   = in_valid && en1 && !rst;
  assign in_clip  = (in_lin[11:0] >= 12'hF80);

  // Segment = position of the leading one in magnitude bits 11:5, minus 4.
  always_comb begin
    // NOTE: default assignment first so every path drives in_seg; without it
    // the tool infers a latch.
    in_seg = 3'd0;
    for (int p = 5; p <= 11; p++) begin
      if (in_lin[p]) in_seg = 3'(p - 4);
    end
  end

  // Mantissa: four bits directly below the leading one, truncated.
  always_comb begin
    s1_mant = s1_mag[4:1];
    case (s1_seg)
      3'd0, 3'd1: s1_mant = s1_mag[4:1];
      3'd2:       s1_mant = s1_mag[5:2];
      3'd3:       s1_mant = s1_mag[6:3];
      3'd4:       s1_mant = s1_mag[7:4];
      3'd5:       s1_mant = s1_mag[8:5];
      3'd6:       s1_mant = s1_mag[9:6];
      default:    s1_mant = s1_mag[10:7];
    endcase
  end

  // Stage 1 valid bit.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge value of its inputs, independent of block order.
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (en1) begin
      s1_valid <= in_valid;
    end
  end

  // Stage 1 payload: captured only on a real transfer, held otherwise.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; the valid bit qualifies them,
    // so resetting them would only add reset fan-out.
    if (accept) begin
      s1_sign <= in_lin[12];
      s1_mag  <= in_lin[11:0];
      s1_seg  <= in_seg;
    end
  end

  // Stage 2: output code and its valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_alaw  <= 8'h00;
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) out_alaw <= {s1_sign, s1_seg, s1_mant};
    end
  end

  // Saturating clip counter; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      clip_count <= '0;
    end else if (accept && in_clip && !(&clip_count)) begin
      clip_count <= clip_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alaw_encoder_stream.sv
// Self-checking bench for alaw_encoder_stream: directed vectors, exhaustive
// sweep with decode-error bound, backpressure, clip saturation, reset flush
// and a long randomized valid/ready run against a behavioural model.
module tb_alaw_encoder_stream;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [12:0]      in_lin;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_alaw;
  logic             out_valid;
  logic             out_ready;
  logic             clr_count;
  logic [CNT_W-1:0] clip_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_accept = 0;

  logic [12:0]      sb_q[$];
  logic [CNT_W-1:0] model_cnt = '0;
  logic             prev_rst  = 1'b1;
  logic             prev_hold = 1'b0;
  logic [7:0]       prev_code = 8'h00;

  always #5 clk = ~clk;

  alaw_encoder_stream #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_lin     (in_lin),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_alaw   (out_alaw),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_count  (clr_count),
    .clip_count (clip_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference encoder written from the segment/mantissa rules.
  function automatic logic [7:0] ref_encode(input logic [12:0] x);
    int m;
    int seg;
    int mant;
    m   = int'(x[11:0]);
    seg = 0;
    if (m >= 32) begin
      seg = 1;
      while ((m >> (seg + 5)) != 0) seg++;
    end
    mant = (seg <= 1) ? ((m >> 1) & 15) : ((m >> seg) & 15);
    return {x[12], 3'(seg), 4'(mant)};
  endfunction

  // Standard A-law magnitude reconstruction (mid-step).
  function automatic int ref_decode_mag(input logic [7:0] c);
    int seg;
    int mant;
    seg  = int'(c[6:4]);
    mant = int'(c[3:0]);
    if (seg == 0) return mant * 2 + 1;
    return (mant * 2 + 33) << (seg - 1);
  endfunction

  function automatic int step_of(input logic [7:0] c);
    return (c[6:4] <= 3'd1) ? 2 : (1 << c[6:4]);
  endfunction

  // Monitor/scoreboard: runs every falling edge while inputs are stable.
  always @(negedge clk) begin
    logic [12:0] x;
    int err;
    if (prev_rst && !rst) begin
      check("post_reset_out_valid", out_valid, 1'b0);
      check("post_reset_out_alaw", out_alaw, 8'h00);
    end
    check("clip_count", clip_count, model_cnt);
    if (rst) begin
      check("rst_in_ready", in_ready, 1'b1);
      sb_q.delete();
      model_cnt = '0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && out_valid) check("hold_stable", out_alaw, prev_code);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL stale_output: got %0h expected no output", out_alaw);
        end else begin
          x = sb_q.pop_front();
          check("code", out_alaw, ref_encode(x));
          err = ref_decode_mag(out_alaw) - int'(x[11:0]);
          if (err < 0) err = -err;
          check("decode_within_step", (err <= step_of(out_alaw)), 1'b1);
          check("sign", out_alaw[7], x[12]);
        end
      end
      if (clr_count) begin
        model_cnt = '0;
      end else if (in_valid && in_ready && in_lin[11:0] >= 12'hF80 && model_cnt != '1) begin
        model_cnt = model_cnt + 1'b1;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(in_lin);
        n_accept++;
      end
      prev_hold = out_valid && !out_ready;
      prev_code = out_alaw;
    end
    prev_rst = rst;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 50) begin
      cyc();
      budget++;
    end
    check(name, sb_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] vec [4];
    logic [7:0]  exp [4];
    logic [7:0]  held;
    int a0;
    int cycles;

    vec[0] = 13'h0000; vec[1] = 13'h0021; vec[2] = 13'h006C; vec[3] = 13'h1FFF;
    exp[0] = 8'h00;    exp[1] = 8'h10;    exp[2] = 8'h2B;    exp[3] = 8'hFF;

    rst = 1'b1; in_lin = '0; in_valid = 1'b0; out_ready = 1'b0; clr_count = 1'b0;

    // Hand-computed pins on the model itself.
    check("pin_enc_0021", ref_encode(13'h0021), 8'h10);
    check("pin_enc_006C", ref_encode(13'h006C), 8'h2B);
    check("pin_enc_1FFF", ref_encode(13'h1FFF), 8'hFF);
    check("pin_enc_1000", ref_encode(13'h1000), 8'h80);
    check("pin_dec_2B", ref_decode_mag(8'h2B), 110);

    repeat (3) cyc();
    sample();
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_clip_count", clip_count, '0);
    cyc();
    rst = 1'b0;

    // Directed stream: outputs appear two cycles after acceptance.
    for (int i = 0; i < 6; i++) begin
      cyc();
      out_ready = 1'b1;
      in_valid  = (i < 4);
      in_lin    = (i < 4) ? vec[i] : 13'h0000;
      sample();
      if (i >= 2) begin
        check("dir_out_valid", out_valid, 1'b1);
        check("dir_out_alaw", out_alaw, exp[i - 2]);
      end else begin
        check("dir_out_idle", out_valid, 1'b0);
      end
    end
    sample();
    check("dir_clip_count", clip_count, 4'd1);

    // Exhaustive sweep of every input code.
    for (int v = 0; v < 8192; v++) begin
      cyc();
      in_valid = 1'b1;
      in_lin   = 13'(v);
    end
    cyc();
    in_valid = 1'b0;
    drain("exh_drain");

    // Backpressure: downstream stalled, upstream keeps offering.
    cyc();
    a0 = n_accept;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_lin    = 13'($urandom);
    repeat (5) begin
      cyc();
      in_lin = 13'($urandom);
    end
    sample();
    check("bp_accepted", n_accept - a0, 2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    held = out_alaw;
    repeat (3) cyc();
    sample();
    check("bp_held", out_alaw, held);
    cyc();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("bp_drain");

    // Clip counter saturation, then clear racing a clipping input.
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (20) begin
      cyc();
      in_valid = 1'b1;
      in_lin   = 13'h0F80;
    end
    cyc();
    in_valid = 1'b0;
    sample();
    check("clip_saturated", clip_count, 4'hF);
    cyc();
    clr_count = 1'b1;
    in_valid  = 1'b1;
    in_lin    = 13'h1F80;
    cyc();
    clr_count = 1'b0;
    in_valid  = 1'b0;
    sample();
    check("clip_clear_wins", clip_count, 4'h0);
    drain("clip_drain");

    // Reset with both stages full.
    cyc();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_lin    = 13'h0FFF;
    repeat (3) cyc();
    sample();
    check("full_out_valid", out_valid, 1'b1);
    check("full_in_ready", in_ready, 1'b0);
    check("full_clip_nonzero", (clip_count != '0), 1'b1);
    cyc();
    rst      = 1'b1;
    in_lin   = 13'h1FFF;
    sample();
    check("rst_forces_ready", in_ready, 1'b1);
    cyc();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sample();
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_clip", clip_count, 4'h0);
    repeat (5) cyc();

    // Randomized valid/ready toggling over 10k accepted samples.
    a0 = n_accept;
    cycles = 0;
    while ((n_accept - a0) < 10000 && cycles < 40000) begin
      cyc();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      clr_count = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) in_lin = {1'($urandom), 12'hF80 | 12'($urandom_range(0, 127))};
      else                            in_lin = 13'($urandom);
      cycles++;
    end
    cyc();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_count = 1'b0;
    check("rand_accepted", ((n_accept - a0) >= 10000), 1'b1);
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
